ssd_scanner: RTL

Parametrised N-digit seven-segment display driver: samples a binary value, converts it to BCD with a sequential double-dabble engine, and time-multiplexes the digits onto common-anode outputs. It replaces the fixed 4-digit score counter path between game logic (`score`) and the board's `An*`/`Ca..Cg`/`Dp` pins. It scales to all 8 digits of the A7 board, adds overflow indication and per-digit decimal points, and makes leading-zero blanking a build option.

---
 rtl/ssd_scanner.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ssd_scanner.sv
// N-digit seven-segment scanner with sequential double-dabble BCD conversion.
// Build option SSD_LEAD_ZERO_BLANK_EN blanks digits above the top non-zero one.
module ssd_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int VALUE_WIDTH = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic [NUM_DIGITS-1:0]  dp_mask,
  output logic [NUM_DIGITS-1:0]  anode,
  output logic [6:0]             ssdOut,
  output logic                   dp,
  output logic                   busy
);

  localparam int NB_RAW = (VALUE_WIDTH + 2) / 3;
  localparam int NB_CAP = (NB_RAW > 10) ? 10 : NB_RAW;
  localparam int NB     = (NB_CAP > NUM_DIGITS) ? NB_CAP : NUM_DIGITS;
  localparam int BW     = 4 * NB;
  localparam int DW     = 4 * NUM_DIGITS;
  localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW     = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
  localparam int RW     = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [VALUE_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]  sdp_q, sdp_d;
  logic [DW-1:0]          dig_q, dig_d;
  logic [NUM_DIGITS-1:0]  mdp_q, mdp_d;
  logic                   ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0]  blk_q, blk_d;
  logic [RW-1:0]          ref_q, ref_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;

  logic [BW-1:0]          adj;
  logic                   ovf;
  logic [NUM_DIGITS-1:0]  blk;
  logic [3:0]             nib;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      sdp_q   <= '0;
      dig_q   <= '0;
      mdp_q   <= '0;
      ovf_q   <= 1'b0;
      blk_q   <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      sdp_q   <= sdp_d;
      dig_q   <= dig_d;
      mdp_q   <= mdp_d;
      ovf_q   <= ovf_d;
      blk_q   <= blk_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    sdp_d   = sdp_q;
    dig_d   = dig_q;
    mdp_d   = mdp_q;
    ovf_d   = ovf_q;
    blk_d   = blk_q;
    busy    = (state_q != IDLE);

    adj = bcd_q;
    for (int k = 0; k < NB; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    // Any non-zero nibble beyond the displayed ones means the value won't fit
    ovf = 1'b0;
    for (int k = NUM_DIGITS; k < NB; k++) begin
      ovf = ovf | (|bcd_q[4*k +: 4]);
    end

    blk = '0;
`ifdef SSD_LEAD_ZERO_BLANK_EN
    begin
      logic hi;
      hi = !ovf;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        hi     = hi & (bcd_q[4*k +: 4] == 4'd0);
        blk[k] = hi;
      end
    end
`endif

    case (state_q)
      IDLE: begin
        bin_d   = value;
        sdp_d   = dp_mask;
        bcd_d   = '0;
        cnt_d   = CW'(VALUE_WIDTH - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        if (cnt_q == '0) state_d = COMMIT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      COMMIT: begin
        dig_d   = bcd_q[DW-1:0];
        mdp_d   = sdp_q;
        ovf_d   = ovf;
        blk_d   = blk;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    nib   = dig_q[{idx_q, 2'b00} +: 4];
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = ovf_q ? 7'b1111110 : seg_of(nib);
    dp_d  = ~mdp_q[idx_q];
    if (blk_q[idx_q]) begin
      an_d  = '1;
      seg_d = 7'b1111111;
    end
  end

  assign anode  = an_q;
  assign ssdOut = seg_q;
  assign dp     = dp_q;

endmodule
